// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS channel encoder: symbol/counter widths,
// control and guard-band symbols, and the per-cycle symbol kind.
package tmds_pkg;

    localparam int unsigned SYM_W = 10;
    localparam int unsigned CNT_W = 5;

    localparam logic [SYM_W-1:0] CTL_SYM_00   = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTL_SYM_01   = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTL_SYM_10   = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTL_SYM_11   = 10'b1010101011;
    localparam logic [SYM_W-1:0] GUARD_SYM_02 = 10'b1011001100;
    localparam logic [SYM_W-1:0] GUARD_SYM_1  = 10'b0100110011;

    typedef enum logic [1:0] {
        SYM_CTRL  = 2'd0,
        SYM_GUARD = 2'd1,
        SYM_VIDEO = 2'd2
    } sym_kind_e;

    function automatic logic [SYM_W-1:0] ctl_symbol(input logic [1:0] c);
        logic [SYM_W-1:0] sym;
        case (c)
            2'b00:   sym = CTL_SYM_00;
            2'b01:   sym = CTL_SYM_01;
            2'b10:   sym = CTL_SYM_10;
            default: sym = CTL_SYM_11;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side bundle for one TMDS channel: de/ctl/guard/data in, symbol out.
interface tmds_channel_encoder_if;
    import tmds_pkg::*;

    logic             de;
    logic [1:0]       ctl;
    logic             video_guard;
    logic [7:0]       data;
    logic [SYM_W-1:0] tmds;

    modport master (output de, ctl, video_guard, data, input tmds);
    modport slave  (input de, ctl, video_guard, data, output tmds);

endinterface

// File: rtl/tmds_popcount8.sv
// Number of ones in an 8-bit vector (0..8).
module tmds_popcount8 (
    input  logic [7:0] bits,
    output logic [3:0] ones
);

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            ones = ones + {3'b000, bits[i]};
        end
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b channel encoder with running-disparity DC balance.
// Define TMDS_PIPELINE_EN to register q_m between the two stages (latency 2).
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter int unsigned CHANNEL = 0
) (
    input  logic pixel_clk,
    input  logic rst,
    tmds_channel_encoder_if.slave bus
);

    logic [3:0]  data_ones;
    logic        use_xnor;
    logic [8:0]  qm_d;
    logic [3:0]  qm_ones_d;
    sym_kind_e   kind_d;
    logic [1:0]  ctl_d;

    logic [8:0]  b_qm;
    logic [3:0]  b_ones;
    sym_kind_e   b_kind;
    logic [1:0]  b_ctl;

    logic signed [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [CNT_W-1:0] diff;
    logic [SYM_W-1:0]        tmds_q, tmds_d;

    tmds_popcount8 u_pop_data (.bits(bus.data), .ones(data_ones));

    always_comb begin
        use_xnor = (data_ones > 4'd4) || ((data_ones == 4'd4) && !bus.data[0]);
        qm_d     = '0;
        qm_d[0]  = bus.data[0];
        for (int unsigned i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ bus.data[i]) : (qm_d[i-1] ^ bus.data[i]);
        end
        qm_d[8] = ~use_xnor;

        if (bus.de)               kind_d = SYM_VIDEO;
        else if (bus.video_guard) kind_d = SYM_GUARD;
        else                      kind_d = SYM_CTRL;
        ctl_d = bus.ctl;
    end

    tmds_popcount8 u_pop_qm (.bits(qm_d[7:0]), .ones(qm_ones_d));

`ifdef TMDS_PIPELINE_EN
    logic [8:0] qm_q;
    logic [3:0] qm_ones_q;
    sym_kind_e  kind_q;
    logic [1:0] ctl_q;

    // Symbol kind and ctl travel with q_m so type and content stay aligned.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            qm_q      <= '0;
            qm_ones_q <= '0;
            kind_q    <= SYM_CTRL;
            ctl_q     <= '0;
        end else begin
            qm_q      <= qm_d;
            qm_ones_q <= qm_ones_d;
            kind_q    <= kind_d;
            ctl_q     <= ctl_d;
        end
    end

    always_comb begin
        b_qm   = qm_q;
        b_ones = qm_ones_q;
        b_kind = kind_q;
        b_ctl  = ctl_q;
    end
`else
    always_comb begin
        b_qm   = qm_d;
        b_ones = qm_ones_d;
        b_kind = kind_d;
        b_ctl  = ctl_d;
    end
`endif

    always_comb begin
        tmds_d = ctl_symbol(b_ctl);
        cnt_d  = '0;
        diff   = $signed({1'b0, b_ones}) - $signed({1'b0, 4'd8 - b_ones});
        case (b_kind)
            SYM_VIDEO: begin
                if ((cnt_q == '0) || (b_ones == 4'd4)) begin
                    tmds_d = {~b_qm[8], b_qm[8], b_qm[8] ? b_qm[7:0] : ~b_qm[7:0]};
                    cnt_d  = cnt_q + (b_qm[8] ? diff : -diff);
                end else if ((!cnt_q[CNT_W-1] && (b_ones > 4'd4)) ||
                             ( cnt_q[CNT_W-1] && (b_ones < 4'd4))) begin
                    tmds_d = {1'b1, b_qm[8], ~b_qm[7:0]};
                    cnt_d  = cnt_q + (b_qm[8] ? 5'sd2 : 5'sd0) - diff;
                end else begin
                    tmds_d = {1'b0, b_qm[8], b_qm[7:0]};
                    cnt_d  = cnt_q - (b_qm[8] ? 5'sd0 : 5'sd2) + diff;
                end
            end
            SYM_GUARD: tmds_d = (CHANNEL == 1) ? GUARD_SYM_1 : GUARD_SYM_02;
            default:   tmds_d = ctl_symbol(b_ctl);
        endcase
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            tmds_q <= CTL_SYM_00;
            cnt_q  <= '0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            assert ((cnt_q >= -5'sd8) && (cnt_q <= 5'sd8));
        end
    end

    assign bus.tmds = tmds_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Self-checking bench for tmds_channel_encoder: CHANNEL 0 and 1 instances
// driven in parallel, compared against a DVI reference model with latency.
module tb_tmds_channel_encoder;

`ifdef TMDS_PIPELINE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic pixel_clk = 1'b0;
    logic rst       = 1'b1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [9:0] s0;
        logic [9:0] s1;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   model_disp = 0;

    tmds_channel_encoder_if if0 ();
    tmds_channel_encoder_if if1 ();

    tmds_channel_encoder #(.CHANNEL(0)) dut0 (.pixel_clk(pixel_clk), .rst(rst), .bus(if0.slave));
    tmds_channel_encoder #(.CHANNEL(1)) dut1 (.pixel_clk(pixel_clk), .rst(rst), .bus(if1.slave));

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) begin
            passes++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // DVI 1.0 encoder rules evaluated with plain integer arithmetic.
    task automatic ref_encode(input logic d, input logic [1:0] c, input logic g,
                              input logic [7:0] dt, inout int disp,
                              output logic [9:0] sym0, output logic [9:0] sym1);
        int         n1;
        int         ones;
        int         zeros;
        logic       xn;
        logic [8:0] qm;
        if (d) begin
            n1 = 0;
            for (int i = 0; i < 8; i++) n1 += int'(dt[i]);
            xn = (n1 > 4) || (n1 == 4 && dt[0] == 1'b0);
            qm = '0;
            qm[0] = dt[0];
            for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ dt[i]) : (qm[i-1] ^ dt[i]);
            qm[8] = ~xn;
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(qm[i]);
            zeros = 8 - ones;
            if (disp == 0 || ones == zeros) begin
                sym0 = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                disp += qm[8] ? (ones - zeros) : (zeros - ones);
            end else if ((disp > 0 && ones > zeros) || (disp < 0 && zeros > ones)) begin
                sym0 = {1'b1, qm[8], ~qm[7:0]};
                disp += 2 * int'(qm[8]) + (zeros - ones);
            end else begin
                sym0 = {1'b0, qm[8], qm[7:0]};
                disp += -2 * (qm[8] ? 0 : 1) + (ones - zeros);
            end
            sym1 = sym0;
        end else if (g) begin
            sym0 = 10'h2CC;
            sym1 = 10'h133;
            disp = 0;
        end else begin
            case (c)
                2'b00:   sym0 = 10'h354;
                2'b01:   sym0 = 10'h0AB;
                2'b10:   sym0 = 10'h154;
                default: sym0 = 10'h2AB;
            endcase
            sym1 = sym0;
            disp = 0;
        end
    endtask

    task automatic restart_model();
        exp_t e;
        exp_q.delete();
        model_disp = 0;
        e.s0 = 10'h354;
        e.s1 = 10'h354;
        e.cnt = 0;
        for (int i = 1; i < LAT; i++) exp_q.push_back(e);
    endtask

    task automatic step(input logic d, input logic [1:0] c, input logic g, input logic [7:0] dt);
        exp_t e;
        if0.de = d; if0.ctl = c; if0.video_guard = g; if0.data = dt;
        if1.de = d; if1.ctl = c; if1.video_guard = g; if1.data = dt;
        ref_encode(d, c, g, dt, model_disp, e.s0, e.s1);
        e.cnt = model_disp;
        exp_q.push_back(e);
        @(posedge pixel_clk);
        #1;
        e = exp_q.pop_front();
        check("tmds_ch0", int'(if0.tmds), int'(e.s0));
        check("tmds_ch1", int'(if1.tmds), int'(e.s1));
        check("cnt", int'(dut0.cnt_q), e.cnt);
        check("cnt_bound", int'((int'(dut0.cnt_q) <= 8) && (int'(dut0.cnt_q) >= -8)), 1);
    endtask

    initial begin
        if0.de = 1'b0; if0.ctl = 2'b00; if0.video_guard = 1'b0; if0.data = 8'h00;
        if1.de = 1'b0; if1.ctl = 2'b00; if1.video_guard = 1'b0; if1.data = 8'h00;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge pixel_clk);
        #1;
        check("reset_tmds_ch0", int'(if0.tmds), 'h354);
        check("reset_tmds_ch1", int'(if1.tmds), 'h354);
        check("reset_cnt", int'(dut0.cnt_q), 0);
        rst = 1'b0;
        restart_model();

        // Idle control, then three zero bytes: 0x100, 0x3FF, 0x100 / -8, +2, -6
        step(1'b0, 2'b00, 1'b0, 8'h00);
        step(1'b1, 2'b00, 1'b0, 8'h00);
        step(1'b1, 2'b00, 1'b0, 8'h00);
        step(1'b1, 2'b00, 1'b0, 8'h00);

        // Remaining control symbols and guard band
        step(1'b0, 2'b01, 1'b0, 8'hA5);
        step(1'b0, 2'b10, 1'b0, 8'h5A);
        step(1'b0, 2'b11, 1'b0, 8'hFF);
        step(1'b0, 2'b00, 1'b1, 8'h00);
        step(1'b0, 2'b11, 1'b1, 8'h3C);
        step(1'b1, 2'b11, 1'b1, 8'hFF);
        step(1'b1, 2'b00, 1'b0, 8'h0F);
        step(1'b0, 2'b00, 1'b0, 8'h00);

        // Random 640-pixel line, then blanking clears the disparity
        for (int i = 0; i < 640; i++) begin
            step(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 2'($urandom_range(0, 3)), 1'b0, 8'($urandom));
        check("cnt_after_line", int'(dut0.cnt_q), 0);

        // Mid-line asynchronous reset
        for (int i = 0; i < 20; i++) step(1'b1, 2'b00, 1'b0, 8'($urandom));
        rst = 1'b1;
        #1;
        check("midline_rst_tmds", int'(if0.tmds), 'h354);
        check("midline_rst_cnt", int'(dut0.cnt_q), 0);
        @(posedge pixel_clk);
        #1;
        rst = 1'b0;
        restart_model();
        step(1'b1, 2'b00, 1'b0, 8'h00);
        step(1'b0, 2'b00, 1'b0, 8'h00);
        step(1'b0, 2'b00, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
